// File: rtl/demux_pkg.sv
// Shared constants and helpers for the flow-controlled 1-to-N stream demux.
// Mode encodings and select-width derivation live here.
package demux_pkg;

    localparam logic MODE_ROUTE = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

    // A single channel select bit is still needed when only one channel exists
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready handshake.
// Allows a same-edge drain and refill so a streaming channel runs at full rate.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         LOAD,
    input  logic [W-1:0] DIN,
    output logic         VALID,
    input  logic         READY,
    output logic [W-1:0] DOUT,
    output logic         FREE
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (LOAD) begin
            r_valid <= 1'b1;
            r_data  <= DIN;
        end else if (READY) begin
            r_valid <= 1'b0;
        end
    end

    assign FREE  = !r_valid || READY;
    assign VALID = r_valid;
    assign DOUT  = r_data;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with routed/broadcast modes,
// per-channel backpressure and a saturating drop counter for bad selects.
module stream_demux_1xn
    import demux_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 8,
    parameter  int CNT_W = 8,
    localparam int M     = sel_width(N)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MODE,
    input  logic [W-1:0]     D,
    input  logic [M-1:0]     S,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [N*W-1:0]   Y,
    output logic [N-1:0]     Y_VALID,
    input  logic [N-1:0]     Y_READY,
    output logic [CNT_W-1:0] DROP_CNT
);

    logic [N-1:0]     w_free;
    logic [N-1:0]     w_sel;
    logic [N-1:0]     w_load;
    logic [31:0]      w_s_ext;
    logic             w_in_range;
    logic             w_bcast;
    logic             w_accept;
    logic             w_drop;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_s_ext    = 32'(S);
    assign w_in_range = w_s_ext < 32'(N);
    assign w_bcast    = (MODE == MODE_BCAST);

    // One-hot decode; stays all-zero for an out-of-range select
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N; k++) begin
            w_sel[k] = (w_s_ext == 32'(k));
        end
    end

    always_comb begin
        IN_READY = 1'b1;
        if (w_bcast) begin
            IN_READY = &w_free;
        end else if (w_in_range) begin
            IN_READY = |(w_free & w_sel);
        end
    end

    assign w_accept = IN_VALID && IN_READY;
    assign w_drop   = w_accept && !w_bcast && !w_in_range;

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load = w_bcast ? '1 : w_sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign DROP_CNT = r_drop_cnt;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_out_slot #(
            .W(W)
        ) u_slot (
            .CLK   (CLK),
            .RST_N (RST_N),
            .LOAD  (w_load[k]),
            .DIN   (D),
            .VALID (Y_VALID[k]),
            .READY (Y_READY[k]),
            .DOUT  (Y[k*W +: W]),
            .FREE  (w_free[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: an 8-channel and a 6-channel (2-bit counter)
// instance driven with directed and random traffic against a channel model.
module tb_stream_demux_1xn;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       mode [2];
    logic [7:0] d    [2];
    logic [2:0] s    [2];
    logic       iv   [2];
    logic [7:0] yr   [2];

    logic        ir0, ir1;
    logic [63:0] y0;
    logic [47:0] y1;
    logic [7:0]  yv0, dc0;
    logic [5:0]  yv1;
    logic [1:0]  dc1;

    int n_chk  = 0;
    int n_pass = 0;

    bit         mv   [2][8];
    logic [7:0] md   [2][8];
    int         mdrop[2];
    int         nch  [2] = '{8, 6};
    int         cmax [2] = '{255, 3};

    always #5 CLK = ~CLK;

    stream_demux_1xn #(.N(8), .W(8), .CNT_W(8)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(mode[0]), .D(d[0]), .S(s[0]),
        .IN_VALID(iv[0]), .IN_READY(ir0), .Y(y0), .Y_VALID(yv0),
        .Y_READY(yr[0]), .DROP_CNT(dc0)
    );

    stream_demux_1xn #(.N(6), .W(8), .CNT_W(2)) u_dut6 (
        .CLK(CLK), .RST_N(RST_N), .MODE(mode[1]), .D(d[1]), .S(s[1]),
        .IN_VALID(iv[1]), .IN_READY(ir1), .Y(y1), .Y_VALID(yv1),
        .Y_READY(yr[1][5:0]), .DROP_CNT(dc1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit exp_ready(input int i);
        bit r;
        if (mode[i]) begin
            r = 1'b1;
            for (int k = 0; k < nch[i]; k++) r &= (!mv[i][k] || yr[i][k]);
        end else if (int'(s[i]) < nch[i]) begin
            r = !mv[i][s[i]] || yr[i][s[i]];
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = iv[i] && exp_ready(i);
            if (!RST_N) begin
                mdrop[i] = 0;
                for (int k = 0; k < 8; k++) begin
                    mv[i][k] = 1'b0;
                    md[i][k] = 8'h00;
                end
            end else begin
                if (acc && !mode[i] && int'(s[i]) >= nch[i] && mdrop[i] < cmax[i])
                    mdrop[i]++;
                for (int k = 0; k < nch[i]; k++) begin
                    if (acc && (mode[i] || int'(s[i]) == k)) begin
                        mv[i][k] = 1'b1;
                        md[i][k] = d[i];
                    end else if (yr[i][k]) begin
                        mv[i][k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic pre();
        #1;
        chk("in_ready0", ir0, exp_ready(0));
        chk("in_ready1", ir1, exp_ready(1));
    endtask

    task automatic post();
        logic [7:0]  ev0, ev1;
        logic [63:0] ey0, ey1;
        model_edge();
        @(posedge CLK);
        #1;
        ev0 = '0; ev1 = '0; ey0 = '0; ey1 = '0;
        for (int k = 0; k < 8; k++) begin
            ev0[k] = mv[0][k];
            ey0[k*8 +: 8] = md[0][k];
        end
        for (int k = 0; k < 6; k++) begin
            ev1[k] = mv[1][k];
            ey1[k*8 +: 8] = md[1][k];
        end
        chk("y_valid0", yv0, ev0);
        chk("y_data0", y0, ey0);
        chk("drop0", dc0, 64'(mdrop[0]));
        chk("y_valid1", yv1, ev1);
        chk("y_data1", y1, ey1);
        chk("drop1", dc1, 64'(mdrop[1]));
        @(negedge CLK);
    endtask

    task automatic step();
        pre();
        post();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mode[i] = 1'b0; d[i] = 8'h00; s[i] = 3'd0;
            iv[i] = 1'b0; yr[i] = 8'hFF; mdrop[i] = 0;
        end
        RST_N = 1'b0;
        iv[0] = 1'b1; s[0] = 3'd3; d[0] = 8'hEE;
        @(negedge CLK);
        step();
        step();
        chk("rst_yvalid", yv0, 0);
        chk("rst_y", y0, 0);
        chk("rst_drop", dc0, 0);

        RST_N = 1'b0;
        iv[0] = 1'b0;
        RST_N = 1'b1;
        #1 chk("rst_release_ready", ir0, 1);

        for (int k = 0; k < 8; k++) begin
            s[0] = 3'(k); d[0] = 8'hA0 + 8'(k); iv[0] = 1'b1;
            step();
            chk("sweep_onehot", yv0, 64'(1) << k);
            chk("sweep_data", y0[k*8 +: 8], 8'hA0 + 8'(k));
        end
        iv[0] = 1'b0;
        step();

        yr[0] = 8'hFB;
        s[0] = 3'd2; d[0] = 8'h11; iv[0] = 1'b1;
        step();
        d[0] = 8'h22;
        pre();
        chk("bp_stall", ir0, 0);
        post();
        chk("bp_hold", y0[23:16], 8'h11);
        step();
        yr[0] = 8'hFF;
        step();
        chk("bp_refill", y0[23:16], 8'h22);
        chk("bp_refill_v", yv0[2], 1);
        s[0] = 3'd5; d[0] = 8'h55;
        step();
        chk("bp_ch5", y0[47:40], 8'h55);
        chk("bp_ch5_v", yv0, 8'h20);
        iv[0] = 1'b0;
        step();

        mode[0] = 1'b1; d[0] = 8'h3C; iv[0] = 1'b1; yr[0] = 8'hFF;
        step();
        chk("bcast_valid", yv0, 8'hFF);
        chk("bcast_data", y0, {8{8'h3C}});
        yr[0] = 8'h7F; d[0] = 8'h5A;
        pre();
        chk("bcast_block", ir0, 0);
        post();
        chk("bcast_nochange", y0, {8{8'h3C}});
        chk("bcast_valid7", yv0, 8'h80);
        iv[0] = 1'b0; mode[0] = 1'b0; yr[0] = 8'hFF;
        step();

        for (int j = 0; j < 6; j++) begin
            mode[1] = 1'b0; s[1] = 3'd6 + 3'(j % 2);
            d[1] = 8'(j); iv[1] = 1'b1;
            pre();
            chk("oor_ready", ir1, 1);
            post();
            chk("oor_novalid", yv1, 0);
            chk("oor_sat", dc1, (j + 1 < 3) ? 64'(j + 1) : 64'd3);
        end
        iv[1] = 1'b0;

        yr[0] = 8'h00;
        s[0] = 3'd1; d[0] = 8'h77; iv[0] = 1'b1;
        step();
        s[0] = 3'd4; d[0] = 8'h44;
        step();
        chk("mid_full", yv0, 8'h12);
        s[0] = 3'd0; d[0] = 8'h99; RST_N = 1'b0;
        step();
        chk("mid_rst_valid", yv0, 0);
        chk("mid_rst_y", y0, 0);
        chk("mid_rst_drop", dc1, 0);
        RST_N = 1'b1; iv[0] = 1'b0; yr[0] = 8'hFF;

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                mode[i] = ($urandom_range(0, 3) == 0);
                d[i]    = 8'($urandom);
                s[i]    = 3'($urandom);
                iv[i]   = ($urandom_range(0, 3) != 0);
                yr[i]   = 8'($urandom) | 8'($urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
